// File: rtl/demo_ctrl_pkg.sv
// Shared types and helpers for the demo control sequencer.
package demo_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_RDWR_SEL  = 4'd1,
    ST_EXT_SEL   = 4'd2,
    ST_EXT_WRITE = 4'd3,
    ST_SLAVE_SEL = 4'd4,
    ST_COUNT_SEL = 4'd5,
    ST_CONFIG    = 4'd6,
    ST_READY     = 4'd7,
    ST_COMM      = 4'd8,
    ST_DONE      = 4'd9
  } state_t;

  // Lowest set bit of mask at index >= from; returns 8 when none is left.
  function automatic logic [3:0] next_set(input logic [7:0] mask, input logic [3:0] from);
    logic [3:0] res;
    res = 4'd8;
    for (int i = 7; i >= 0; i--)
      if (mask[i] && (4'(i) >= from)) res = 4'(i);
    return res;
  endfunction

endpackage

// File: rtl/demo_ctrl_if.sv
// Bus between the sequencer and the master instances.
interface demo_ctrl_if #(
  parameter int MASTER_COUNT = 2,
  parameter int SID_W        = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int CNT_W        = 12
);
  logic [MASTER_COUNT-1:0] rd_wr;
  logic                    ext_we;
  logic [DATA_WIDTH-1:0]   ext_data;
  logic                    cfg_we;
  logic [SID_W-1:0]        cfg_slave;
  logic [CNT_W-1:0]        cfg_count;
  logic                    start;
  logic [MASTER_COUNT-1:0] m_done;

  modport master (output rd_wr, ext_we, ext_data, cfg_we, cfg_slave, cfg_count, start,
                  input  m_done);
  modport slave  (input  rd_wr, ext_we, ext_data, cfg_we, cfg_slave, cfg_count, start,
                  output m_done);
endinterface

// File: rtl/demo_ctrl_rise_edge.sv
// Rising-edge detector for an already-debounced level: one flop plus AND.
module rise_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_in,
  output logic o_rise
);
  logic r_prev;

  always_ff @(posedge clk) begin
    if (rst) r_prev <= 1'b0;
    else     r_prev <= i_in;
  end

  assign o_rise = i_in & ~r_prev;
endmodule

// File: rtl/demo_ctrl_fsm.sv
// Operator-driven configuration sequencer for MASTER_COUNT serial-bus masters.
// Optional comm watchdog: define DEMO_CTRL_TIMEOUT_EN.
module demo_ctrl_fsm
  import demo_ctrl_pkg::*;
#(
  parameter int MASTER_COUNT   = 2,
  parameter int SLAVE_COUNT    = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int CNT_W          = 12,
  parameter int SW_W           = 18,
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump,
  input  logic [SW_W-1:0] sw,
  output logic [3:0]      state,
  output logic [2:0]      cur_master,
  output logic            timeout,
  demo_ctrl_if.master     bus
);
  localparam int SID_W = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;
  localparam int IW    = (MASTER_COUNT > 1) ? $clog2(MASTER_COUNT) : 1;
  localparam logic [SID_W-1:0] SID_MAX = SID_W'(SLAVE_COUNT - 1);

  state_t                               r_state;
  logic [2:0]                           r_cur;
  logic [MASTER_COUNT-1:0]              r_rd_wr, r_ext_mask, r_done_seen;
  logic [MASTER_COUNT-1:0][SID_W-1:0]   r_slave;
  logic [MASTER_COUNT-1:0][CNT_W-1:0]   r_count;
  logic                                 r_step, r_ext_adv;
  logic                                 r_ext_we, r_cfg_we, r_start;
  logic [DATA_WIDTH-1:0]                r_ext_data;
  logic [SID_W-1:0]                     r_cfg_slave;
  logic [CNT_W-1:0]                     r_cfg_count;

  logic                    w_step, w_last, w_expire;
  logic [MASTER_COUNT-1:0] w_sw_m, w_ext_m, w_seen;
  logic [SID_W-1:0]        w_sid_in;
  logic [CNT_W-1:0]        w_cnt_in;
  logic [3:0]              w_first, w_nxt_ext;
  logic [IW-1:0]           w_idx, w_idx_n;
  logic                    w_unused_sw;

  rise_edge u_jump (.clk(clk), .rst(rst), .i_in(jump), .o_rise(w_step));

  assign w_sw_m      = sw[MASTER_COUNT-1:0];
  assign w_ext_m     = w_sw_m & r_rd_wr;
  assign w_sid_in    = (sw[SID_W-1:0] > SID_MAX) ? SID_MAX : sw[SID_W-1:0];
  assign w_cnt_in    = (sw[CNT_W-1:0] == '0) ? CNT_W'(1) : sw[CNT_W-1:0];
  assign w_seen      = r_done_seen | bus.m_done;
  assign w_last      = (r_cur == 3'(MASTER_COUNT - 1));
  assign w_idx       = r_cur[IW-1:0];
  assign w_idx_n     = IW'(r_cur + 3'd1);
  assign w_first     = next_set(8'(w_ext_m), 4'd0);
  assign w_nxt_ext   = next_set(8'(r_ext_mask), {1'b0, r_cur} + 4'd1);
  assign w_unused_sw = ^sw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_rd_wr     <= '0;
      r_ext_mask  <= '0;
      r_done_seen <= '0;
      r_slave     <= '0;
      r_count     <= '0;
      r_step      <= 1'b0;
      r_ext_adv   <= 1'b0;
      r_ext_we    <= 1'b0;
      r_ext_data  <= '0;
      r_cfg_we    <= 1'b0;
      r_cfg_slave <= '0;
      r_cfg_count <= '0;
      r_start     <= 1'b0;
    end else begin
      r_step    <= w_step;
      r_ext_we  <= 1'b0;
      r_cfg_we  <= 1'b0;
      r_start   <= 1'b0;
      r_ext_adv <= 1'b0;
      case (r_state)
        ST_IDLE: if (r_step) r_state <= ST_RDWR_SEL;
        ST_RDWR_SEL: if (r_step) begin
          r_rd_wr <= w_sw_m;
          r_cur   <= '0;
          r_state <= (w_sw_m != '0) ? ST_EXT_SEL : ST_SLAVE_SEL;
        end
        ST_EXT_SEL: if (r_step) begin
          r_ext_mask <= w_ext_m;
          if (w_ext_m == '0) begin
            r_state <= ST_SLAVE_SEL;
            r_cur   <= '0;
          end else begin
            r_state <= ST_EXT_WRITE;
            r_cur   <= w_first[2:0];
          end
        end
        // cur_master holds through the strobe cycle, then advances
        ST_EXT_WRITE: begin
          if (r_ext_adv) begin
            if (w_nxt_ext[3]) begin
              r_state <= ST_SLAVE_SEL;
              r_cur   <= '0;
            end else begin
              r_cur   <= w_nxt_ext[2:0];
            end
          end else if (r_step) begin
            r_ext_we   <= 1'b1;
            r_ext_data <= sw[DATA_WIDTH-1:0];
            r_ext_adv  <= 1'b1;
          end
        end
        ST_SLAVE_SEL: if (r_step) begin
          r_slave[w_idx] <= w_sid_in;
          if (w_last) begin
            r_state <= ST_COUNT_SEL;
            r_cur   <= '0;
          end else begin
            r_cur   <= r_cur + 3'd1;
          end
        end
        // First cfg_we is issued on CONFIG entry so pulse k lines up with CONFIG cycle k
        ST_COUNT_SEL: if (r_step) begin
          r_count[w_idx] <= w_cnt_in;
          if (w_last) begin
            r_state     <= ST_CONFIG;
            r_cur       <= '0;
            r_cfg_we    <= 1'b1;
            r_cfg_slave <= r_slave[0];
            r_cfg_count <= (MASTER_COUNT == 1) ? w_cnt_in : r_count[0];
          end else begin
            r_cur <= r_cur + 3'd1;
          end
        end
        ST_CONFIG: begin
          if (w_last) begin
            r_state <= ST_READY;
            r_cur   <= '0;
          end else begin
            r_cur       <= r_cur + 3'd1;
            r_cfg_we    <= 1'b1;
            r_cfg_slave <= r_slave[w_idx_n];
            r_cfg_count <= r_count[w_idx_n];
          end
        end
        ST_READY: if (r_step) begin
          r_state     <= ST_COMM;
          r_start     <= 1'b1;
          r_done_seen <= '0;
        end
        ST_COMM: begin
          r_done_seen <= w_seen;
          if ((&w_seen) || w_expire) r_state <= ST_DONE;
        end
        ST_DONE: if (r_step) begin
          r_state     <= ST_IDLE;
          r_done_seen <= '0;
          r_ext_mask  <= '0;
          r_cur       <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef DEMO_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmr;
  logic          r_timeout;

  always_ff @(posedge clk) begin
    if (rst || r_state != ST_COMM) r_tmr <= '0;
    else                           r_tmr <= r_tmr + 1'b1;
  end

  assign w_expire = (r_tmr == TW'(TIMEOUT_CYCLES - 1));

  // Completion in the expiry cycle wins over the watchdog
  always_ff @(posedge clk) begin
    if (rst)                                                  r_timeout <= 1'b0;
    else if (r_state == ST_COMM && w_expire && !(&w_seen))    r_timeout <= 1'b1;
    else if (r_state == ST_DONE && r_step)                    r_timeout <= 1'b0;
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  assign state         = r_state;
  assign cur_master    = r_cur;
  assign bus.rd_wr     = r_rd_wr;
  assign bus.ext_we    = r_ext_we;
  assign bus.ext_data  = r_ext_data;
  assign bus.cfg_we    = r_cfg_we;
  assign bus.cfg_slave = r_cfg_slave;
  assign bus.cfg_count = r_cfg_count;
  assign bus.start     = r_start;
endmodule

// File: tb/tb_demo_ctrl_fsm.sv
// Scoreboard bench for demo_ctrl_fsm: strobes are matched against queued expectations.
module tb_demo_ctrl_fsm;
  localparam int MC = 2, SC = 3, DW = 16, CW = 12, SWW = 18, TO = 20;

  typedef struct { int cur; int a; int b; } exp_t;

  logic           clk = 1'b0, rst = 1'b1, jump = 1'b0;
  logic [SWW-1:0] sw = '0;
  logic [3:0]     state;
  logic [2:0]     cur_master;
  logic           timeout;

  demo_ctrl_if #(.MASTER_COUNT(MC), .SID_W(2), .DATA_WIDTH(DW), .CNT_W(CW)) bus_if ();

  demo_ctrl_fsm #(.MASTER_COUNT(MC), .SLAVE_COUNT(SC), .DATA_WIDTH(DW), .CNT_W(CW),
                  .SW_W(SWW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .jump(jump), .sw(sw), .state(state),
    .cur_master(cur_master), .timeout(timeout), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0, n_err = 0, n_cfg_cyc = 0;
  exp_t q_cfg[$], q_ext[$];
  int   q_start[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: every pulse must match the head of its queue
  always @(negedge clk) begin
    exp_t e;
    if (state == 4'd6) n_cfg_cyc++;
    if (bus_if.cfg_we) begin
      chk("cfg_in_config", state, 6);
      if (q_cfg.size() == 0) chk("cfg_unexpected", bus_if.cfg_we, 0);
      else begin
        e = q_cfg.pop_front();
        chk("cfg_cur", cur_master, e.cur);
        chk("cfg_slave", bus_if.cfg_slave, e.a);
        chk("cfg_count", bus_if.cfg_count, e.b);
      end
    end
    if (bus_if.ext_we) begin
      if (q_ext.size() == 0) chk("ext_unexpected", bus_if.ext_we, 0);
      else begin
        e = q_ext.pop_front();
        chk("ext_cur", cur_master, e.cur);
        chk("ext_data", bus_if.ext_data, e.a);
      end
    end
    if (bus_if.start) begin
      if (q_start.size() == 0) chk("start_unexpected", bus_if.start, 0);
      else begin
        void'(q_start.pop_front());
        chk("start_state", state, 8);
      end
    end
  end

  task automatic do_step(input logic [SWW-1:0] v);
    sw = v;
    jump = 1'b1;
    repeat (2) @(posedge clk);
    #1 jump = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic go_comm();
    q_start.push_back(1);
    jump = 1'b1;
    @(posedge clk);
    #1 jump = 1'b0;
    for (int i = 0; i < 8 && state != 4'd8; i++) @(negedge clk);
    chk("comm_entry", state, 8);
  endtask

  // IDLE -> read-only -> slave0, slave1 -> count0; caller issues the last count step
  task automatic cfg_run(input logic [SWW-1:0] s0, input logic [SWW-1:0] s1,
                         input logic [SWW-1:0] c0);
    do_step('0);  chk("to_rdwr", state, 1);
    do_step('0);  chk("rdwr_skip_ext", state, 4);
    do_step(s0);  chk("slave0_cur", cur_master, 1);
    do_step(s1);  chk("to_count", state, 5); chk("count_cur0", cur_master, 0);
    do_step(c0);  chk("count0_cur", cur_master, 1);
  endtask

  initial begin
    bus_if.m_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", state, 0);
    chk("rst_cur", cur_master, 0);
    chk("rst_rdwr", bus_if.rd_wr, 0);
    chk("rst_extdata", bus_if.ext_data, 0);
    chk("rst_cfgslave", bus_if.cfg_slave, 0);
    chk("rst_cfgcount", bus_if.cfg_count, 0);
    chk("rst_strobes", {bus_if.ext_we, bus_if.cfg_we, bus_if.start, timeout}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Run A: read-only, slaves 1/2, counts 5/7, exact COMM timing
    cfg_run(18'd1, 18'd2, 18'd5);
    q_cfg.push_back('{0, 1, 5});
    q_cfg.push_back('{1, 2, 7});
    n_cfg_cyc = 0;
    do_step(18'd7);
    chk("a_ready", state, 7);
    chk("a_config_len", n_cfg_cyc, MC);
    go_comm();
    for (int k = 0; k < 12; k++) begin
      chk("a_comm_state", state, (k <= 10) ? 8 : 9);
      chk("a_start_once", bus_if.start, (k == 0) ? 1 : 0);
      bus_if.m_done = (k == 3) ? 2'b01 : (k == 10) ? 2'b10 : 2'b00;
      @(negedge clk);
    end
    bus_if.m_done = '0;
    chk("a_timeout_clear", timeout, 0);
    do_step('0);
    chk("a_back_idle", state, 0);

    // Run B: write path, ext mask 2'b10, saturation and zero count
    do_step('0);           chk("b_rdwr", state, 1);
    do_step(18'h3);        chk("b_extsel", state, 2); chk("b_rdwr_val", bus_if.rd_wr, 3);
    do_step(18'h3FFF2);    chk("b_extwrite", state, 3); chk("b_ext_cur", cur_master, 1);
    q_ext.push_back('{1, 16'hBEEF, 0});
    do_step(18'h3BEEF);    chk("b_after_ext", state, 4); chk("b_after_ext_cur", cur_master, 0);
    do_step(18'd7);        chk("b_slave1", cur_master, 1);
    do_step(18'd0);        chk("b_count", state, 5);
    q_cfg.push_back('{0, 2, 1});
    q_cfg.push_back('{1, 0, 3000});
    do_step(18'h3F000);    chk("b_count1", cur_master, 1);
    do_step(18'd3000);     chk("b_ready", state, 7);
    go_comm();
    do_step('0);           chk("b_step_dropped", state, 8);
    bus_if.m_done = 2'b11;
    @(negedge clk);
    @(negedge clk);
    chk("b_done", state, 9);
    bus_if.m_done = '0;
    do_step('0);           chk("b_idle", state, 0);

`ifdef DEMO_CTRL_TIMEOUT_EN
    // Run D: watchdog with no m_done
    cfg_run(18'd1, 18'd1, 18'd2);
    q_cfg.push_back('{0, 1, 2});
    q_cfg.push_back('{1, 1, 2});
    do_step(18'd2);        chk("d_ready", state, 7);
    go_comm();
    for (int k = 0; k < 22; k++) begin
      chk("d_state", state, (k < TO) ? 8 : 9);
      chk("d_timeout", timeout, (k < TO) ? 0 : 1);
      @(negedge clk);
    end
    do_step('0);
    chk("d_idle", state, 0);
    chk("d_timeout_cleared", timeout, 0);
`endif

    // Run C: reset after the first CONFIG strobe
    cfg_run(18'd1, 18'd1, 18'd9);
    q_cfg.push_back('{0, 1, 9});
    sw = 18'd9;
    jump = 1'b1;
    for (int i = 0; i < 20 && !bus_if.cfg_we; i++) @(negedge clk);
    chk("c_first_cfg", bus_if.cfg_we, 1);
    rst = 1'b1;
    jump = 1'b0;
    @(negedge clk);
    chk("c_rst_state", state, 0);
    chk("c_rst_cur", cur_master, 0);
    chk("c_rst_extdata", bus_if.ext_data, 0);
    chk("c_rst_cfg", {bus_if.cfg_slave, bus_if.cfg_count}, 0);
    chk("c_rst_strobes", {bus_if.ext_we, bus_if.cfg_we, bus_if.start, timeout}, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("c_stay_idle", state, 0);

    chk("q_cfg_empty", q_cfg.size(), 0);
    chk("q_ext_empty", q_ext.size(), 0);
    chk("q_start_empty", q_start.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "time limit");
  end
endmodule
